// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer and the UART transmitter.
//   data_i   - byte to send, sampled on acceptance
//   valid_i  - producer request
//   parity_i - 1 appends an even-parity bit to the frame
//   ready_o  - transmitter idle; byte accepted when valid_i && ready_o at an edge
interface uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       parity_i;
  logic       ready_o;

  modport master (output data_i, valid_i, parity_i, input ready_o);
  modport slave  (input data_i, valid_i, parity_i, output ready_o);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, LSB first, optional even parity, one stop bit.
// Each bit lasts DIV baud ticks; a baud tick occurs every PSCALER sysclk cycles.
//   sysclk  - clock, rising edge
//   reset   - synchronous, active-high
//   bus     - byte handshake (data_i, valid_i, parity_i in; ready_o out)
//   tx_o    - serial line, idle high
//   busy_o  - high from the cycle after acceptance through the done_o cycle
//   done_o  - one-cycle pulse in the final stop-bit cycle, ready_o high with it
module uart_tx #(
  parameter int unsigned N       = 8,
  parameter int unsigned PSCALER = 1,
  parameter int unsigned DIV     = 10
) (
  input  logic     sysclk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx_o,
  output logic     busy_o,
  output logic     done_o
);

  localparam int unsigned TW = 8;
  localparam logic [N-1:0]  PS_LAST  = N'(PSCALER - 1);
  localparam logic [N-1:0]  PS_PRE   = N'((PSCALER > 1) ? PSCALER - 2 : 0);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] DIV_PRE  = TW'(DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic tick;
  logic bit_end;
  logic stop_pre;

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    done_d  = 1'b0;

    tick    = (pcnt_q == PS_LAST);
    bit_end = tick && (tcnt_q == DIV_LAST);
    // Stop bit ends one cycle early in state terms so the done_o/IDLE cycle
    // is the last stop-bit cycle; back-to-back frames then have no gap.
    if (PSCALER > 1) begin
      stop_pre = (tcnt_q == DIV_LAST) && (pcnt_q == PS_PRE);
    end else begin
      stop_pre = (tcnt_q == DIV_PRE);
    end

    if (state_q != S_IDLE) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        tcnt_d = (tcnt_q == DIV_LAST) ? '0 : tcnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Counters held at zero so every frame starts at prescaler phase 0.
        pcnt_d = '0;
        tcnt_d = '0;
        idx_d  = '0;
        if (bus.valid_i) begin
          data_d  = bus.data_i;
          par_d   = bus.parity_i;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = par_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (stop_pre) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[idx_d];
      S_PARITY: tx_d = ^data_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) || done_d;
  end

  // State and output registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for two uart_tx instances
//   u=0: PSCALER=2, DIV=4 (8 cycles/bit); u=1: PSCALER=1, DIV=2 (2 cycles/bit).
// Stimulus pushes each accepted byte; a negedge monitor captures tx_o from the
// first low cycle to done_o and compares it against a waveform built from the
// frame rules.
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v, valid_v, par_v;
  logic [7:0] data_v [2];
  logic [1:0] tx, busy, done, rdy;

  int vectors     = 0;
  int miscompares = 0;

  frame_t     exp_q [2][$];
  bit         cap_on  [2];
  int         cap_n   [2];
  logic [95:0] cap_wave [2];
  bit         hs_ok   [2];

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  assign bus_a.valid_i  = valid_v[0];
  assign bus_a.data_i   = data_v[0];
  assign bus_a.parity_i = par_v[0];
  assign rdy[0]         = bus_a.ready_o;
  assign bus_b.valid_i  = valid_v[1];
  assign bus_b.data_i   = data_v[1];
  assign bus_b.parity_i = par_v[1];
  assign rdy[1]         = bus_b.ready_o;

  uart_tx #(.N(8), .PSCALER(2), .DIV(4)) dut_a (
    .sysclk(clk), .reset(rst_v[0]), .bus(bus_a),
    .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  uart_tx #(.N(8), .PSCALER(1), .DIV(2)) dut_b (
    .sysclk(clk), .reset(rst_v[1]), .bus(bus_b),
    .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  function automatic int cpb_of(int u);
    return (u == 0) ? 8 : 2;
  endfunction

  // Frame as a list of bit levels, each stretched to cpb cycles.
  function automatic int exp_len(frame_t f, int cpb);
    return (f.p ? 11 : 10) * cpb;
  endfunction

  function automatic logic [95:0] exp_wave(frame_t f, int cpb);
    logic bits [11];
    int   nb;
    logic [95:0] w;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = f.d[i];
    nb = 9;
    if (f.p) begin
      bits[9] = ^f.d;
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb++;
    w = '0;
    for (int k = 0; k < nb * cpb; k++) w[k] = bits[k / cpb];
    return w;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: capture each frame and compare with the scoreboard head.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_v[u]) begin
        cap_on[u] = 1'b0;
        exp_q[u].delete();
      end else begin
        if (!cap_on[u]) begin
          chk("stray_done", done[u], 1'b0);
          if (tx[u] == 1'b0) begin
            cap_on[u]   = 1'b1;
            cap_n[u]    = 0;
            cap_wave[u] = '0;
            hs_ok[u]    = 1'b1;
          end
        end
        if (cap_on[u]) begin
          if (cap_n[u] < 96) cap_wave[u][cap_n[u]] = tx[u];
          cap_n[u]++;
          hs_ok[u] = hs_ok[u] && busy[u] && (rdy[u] == done[u]);
          if (done[u]) begin
            cap_on[u] = 1'b0;
            if (exp_q[u].size() == 0) begin
              chk("extra_frame", 1'b1, exp_q[u].size() == 0 ? 1'b0 : 1'b1);
            end else begin
              frame_t f;
              f = exp_q[u].pop_front();
              chk("frame_len", 128'(cap_n[u]), 128'(exp_len(f, cpb_of(u))));
              chk("frame_wave", cap_wave[u], exp_wave(f, cpb_of(u)));
              chk("busy_ready_in_frame", hs_ok[u], 1'b1);
            end
          end else if (cap_n[u] > 96) begin
            cap_on[u] = 1'b0;
            chk("frame_overrun", 128'(cap_n[u]), 128'(96));
          end
        end
      end
    end
  end

  // Offer a byte, wait for acceptance, push it. Called at posedge+1.
  task automatic send(int u, logic [7:0] d, logic p, bit hold);
    int t;
    frame_t f;
    t = 0;
    data_v[u]  = d;
    par_v[u]   = p;
    valid_v[u] = 1'b1;
    while (!rdy[u] && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy[u]) begin
      chk("ready_timeout", rdy[u], 1'b1);
      valid_v[u] = 1'b0;
      return;
    end
    @(posedge clk);
    f.d = d;
    f.p = p;
    exp_q[u].push_back(f);
    #1;
    if (!hold) valid_v[u] = 1'b0;
    chk("accept_busy", busy[u], 1'b1);
    chk("accept_tx_low", tx[u], 1'b0);
  endtask

  task automatic wait_idle(int u);
    int t;
    t = 0;
    while ((busy[u] || !rdy[u]) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", busy[u], 1'b0);
  endtask

  task automatic check_reset_state(int u);
    chk("rst_tx", tx[u], 1'b1);
    chk("rst_ready", rdy[u], 1'b1);
    chk("rst_busy", busy[u], 1'b0);
    chk("rst_done", done[u], 1'b0);
  endtask

  initial begin
    rst_v   = 2'b11;
    valid_v = 2'b00;
    par_v   = 2'b00;
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    rst_v = 2'b00;

    // Directed frames, 8 cycles/bit.
    send(0, 8'h55, 1'b0, 1'b0); wait_idle(0);
    send(0, 8'h07, 1'b1, 1'b0); wait_idle(0);
    send(0, 8'h03, 1'b1, 1'b0); wait_idle(0);

    // Back-to-back with valid held; data changes mid-frame must not leak in.
    send(0, 8'hA5, 1'b0, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b0);
    wait_idle(0);

    // Requests while busy are ignored.
    send(0, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      data_v[0]  = 8'($urandom);
      par_v[0]   = 1'($urandom);
      valid_v[0] = 1'(i % 2);
      @(posedge clk); #1;
    end
    valid_v[0] = 1'b0;
    wait_idle(0);

    // Reset during data bit 3 of 0xFF, with valid also high: reset wins.
    send(0, 8'hFF, 1'b0, 1'b0);
    repeat (34) begin @(posedge clk); #1; end
    rst_v[0]   = 1'b1;
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h00;
    par_v[0]   = 1'b0;
    @(posedge clk); #1;
    check_reset_state(0);
    rst_v[0] = 1'b0;
    send(0, 8'h00, 1'b0, 1'b0);
    wait_idle(0);

    // Random frames, some back-to-back.
    for (int i = 0; i < 10; i++) begin
      bit hold;
      hold = (i == 9) ? 1'b0 : 1'($urandom);
      send(0, 8'($urandom), 1'($urandom), hold);
      if (!hold) begin
        wait_idle(0);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    end
    wait_idle(0);

    // Fast instance, 2 cycles/bit.
    send(1, 8'h81, 1'b0, 1'b0); wait_idle(1);
    for (int i = 0; i < 8; i++) begin
      bit hold;
      hold = (i == 7) ? 1'b0 : 1'($urandom);
      send(1, 8'($urandom), 1'($urandom), hold);
      if (!hold) wait_idle(1);
    end
    wait_idle(1);

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_empty_a", 128'(exp_q[0].size()), 128'(0));
    chk("scoreboard_empty_b", 128'(exp_q[1].size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter N, default 8: prescaler counter width in bits.
REQ-002 Parameter PSCALER, default 1: sysclk cycles per baud tick, legal range 1..2^N.
REQ-003 Parameter DIV, default 10: baud ticks per serial bit, legal range 2..255.
REQ-004 Port sysclk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  input  1: synchronous reset, active-high.
REQ-006 Port data_i  input  8: byte to transmit, sampled on acceptance.
REQ-007 Port valid_i  input  1: data_i valid request.
REQ-008 Port parity_i  input  1: sampled on acceptance; 1 = append even-parity bit, 0 = no parity bit.
REQ-009 Port ready_o  output  1: high only in IDLE; byte accepted when valid_i && ready_o at a sysclk edge.
REQ-010 Port tx_o  output  1: serial line, idle high, LSB first.
REQ-011 Port busy_o  output  1: high from the cycle after acceptance until the frame completes.
REQ-012 Port done_o  output  1: one-cycle pulse at frame completion.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; any unreachable encoding SHALL return to IDLE on the next edge.
REQ-014 Acceptance SHALL register data_i and parity_i, clear the prescaler and tick counters, and move to START; tx_o SHALL be low on the cycle after acceptance.
REQ-015 Baud tick: prescaler counts 0..PSCALER-1 and wraps; tick asserted when count == PSCALER-1; with PSCALER=1 tick asserts every cycle.
REQ-016 Each bit SHALL hold tx_o for exactly DIV ticks = DIV*PSCALER sysclk cycles, independent of prescaler phase before acceptance.
REQ-017 START drives 0; DATA drives data bits 0..7 in order via a 3-bit index; PARITY drives XOR of the 8 data bits; STOP drives 1.
REQ-018 After bit 7: go to PARITY if latched parity=1, else STOP.
REQ-019 At the end of STOP: pulse done_o for one cycle, enter IDLE, drive ready_o high in that same cycle.
REQ-020 Frame length SHALL be 10*DIV*PSCALER cycles without parity and 11*DIV*PSCALER with parity, measured from the first low cycle of tx_o to the done_o cycle.
REQ-021 Back-to-back: a valid_i held high SHALL be accepted in the done_o cycle, so the next start bit follows the stop bit with zero idle cycles.
REQ-022 Changes on data_i or parity_i after acceptance SHALL NOT affect the frame in progress.
REQ-023 valid_i while busy SHALL be ignored, with no queuing.
REQ-024 Bit and tick counters SHALL be wide enough for DIV-1 and SHALL NOT wrap within a bit.

Reset
REQ-025 reset high at an edge SHALL force IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, and clear all counters and latched data, including mid-frame.
REQ-026 If reset and valid_i are high in the same cycle, reset SHALL win and the byte SHALL NOT be accepted.
REQ-027 After reset deasserts, a valid_i SHALL be accepted on the first edge.

Verification (PSCALER=2, DIV=4, 8 cycles/bit)
REQ-028 Send 0x55, parity_i=0 -> tx_o holds 0,1,0,1,0,1,0,1,0,1 for 8 cycles per level; done_o at cycle 80; busy_o high for 80 cycles.
REQ-029 Send 0x07, parity_i=1 -> parity bit 1, frame 88 cycles; send 0x03, parity_i=1 -> parity bit 0.
REQ-030 Hold valid_i high with 0xA5 then 0x3C -> second start bit begins on the cycle after the first frame's done_o; stop bit is exactly 8 cycles.
REQ-031 Assert reset during data bit 3 of 0xFF -> tx_o=1, ready_o=1 on the next cycle; a new 0x00 frame then completes normally.
REQ-032 Toggle data_i and pulse valid_i while busy -> transmitted byte unchanged, no extra frame.
REQ-033 Run PSCALER=1, DIV=2 with 0x81 -> 2 cycles/bit, frame 20 cycles, bit pattern 0,1,0,0,0,0,0,0,1,1.
